// File: rtl/pdp_rdma_ig_cdt.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// pdp_rdma_ig_cdt_chk
//   Protocol checker for the credit pool. A credit return while the pool is
//   already full means the egress side popped more atoms than were ever
//   reserved.
// Ports:
//   clk, rst    : clock and asynchronous active-high reset
//   pop         : one-atom credit return
//   credit      : current credit count of the ingress block
// ---------------------------------------------------------------------------
module pdp_rdma_ig_cdt_chk #(
  parameter int LAT_DEPTH = 64,
  parameter int CR_W      = 7
) (
  input logic            clk,
  input logic            rst,
  input logic            pop,
  input logic [CR_W-1:0] credit
);

  // Credit return while the pool is full is an egress accounting error.
  a_no_pop_when_full : assert property (
    @(posedge clk) disable iff (rst) !(pop && (credit == CR_W'(LAT_DEPTH)))
  );

endmodule

// ---------------------------------------------------------------------------
// pdp_rdma_ig_cdt
//   PDP RDMA ingress. Walks an input cube (surfaces x lines x atoms), issues
//   burst read requests of at most MAX_BURST atoms, pushes one matching
//   context entry per request and reserves latency-FIFO credits (in atoms)
//   before each request so returning data can never overflow the egress FIFO.
// Ports:
//   nvdla_core_clk / nvdla_core_rst : clock, asynchronous active-high reset
//   op_en                           : one-cycle layer start (IDLE only)
//   cfg_*                           : cube geometry, sampled on op_en
//   rd_req_valid/ready/pd           : read request {size, addr}
//   ig2cq_pvld/prdy/pd              : context entry {layer_end, surf_end,
//                                     line_end, size}
//   cdt_lat_fifo_pop                : returns one atom of credit
//   eg2ig_done                      : egress drained the layer (WAIT only)
//   layer_done                      : one-cycle pulse at layer end
//   busy                            : state is not IDLE
//   perf_read_stall                 : saturating rd_req stall-cycle counter
// ---------------------------------------------------------------------------
module pdp_rdma_ig_cdt #(
  parameter int AW         = 64,
  parameter int ATOM_BYTES = 32,
  parameter int MAX_BURST  = 8,
  parameter int SIZE_W     = 4,
  parameter int LAT_DEPTH  = 64,
  parameter int CNT_W      = 13
) (
  input  logic                 nvdla_core_clk,
  input  logic                 nvdla_core_rst,
  input  logic                 op_en,
  input  logic [AW-1:0]        cfg_base_addr,
  input  logic [31:0]          cfg_line_stride,
  input  logic [31:0]          cfg_surf_stride,
  input  logic [CNT_W-1:0]     cfg_width,
  input  logic [CNT_W-1:0]     cfg_height,
  input  logic [CNT_W-1:0]     cfg_surfaces,
  output logic                 rd_req_valid,
  input  logic                 rd_req_ready,
  output logic [AW+SIZE_W-1:0] rd_req_pd,
  output logic                 ig2cq_pvld,
  input  logic                 ig2cq_prdy,
  output logic [SIZE_W+2:0]    ig2cq_pd,
  input  logic                 cdt_lat_fifo_pop,
  input  logic                 eg2ig_done,
  output logic                 layer_done,
  output logic                 busy,
  output logic [31:0]          perf_read_stall
);

  localparam int SHIFT = $clog2(ATOM_BYTES);
  localparam int CR_W  = $clog2(LAT_DEPTH + 1);
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GEN  = 2'd1,
    SEND = 2'd2,
    WAIT = 2'd3
  } state_t;

  state_t               state_r;
  logic [31:0]          line_stride_r;
  logic [31:0]          surf_stride_r;
  logic [CNT_W-1:0]     cfg_width_r;
  logic [CNT_W-1:0]     cfg_height_r;
  logic [CNT_W-1:0]     cfg_surfaces_r;
  logic [AW-1:0]        surf_addr_r;
  logic [AW-1:0]        line_addr_r;
  logic [CNT_W-1:0]     atom_cnt_r;
  logic [CNT_W-1:0]     line_cnt_r;
  logic [CNT_W-1:0]     surf_cnt_r;
  logic [CR_W-1:0]      credit_r;
  logic                 rd_req_valid_r;
  logic [AW+SIZE_W-1:0] rd_req_pd_r;
  logic                 ig2cq_pvld_r;
  logic [SIZE_W+2:0]    ig2cq_pd_r;
  logic                 layer_done_r;
  logic                 busy_r;
  logic [31:0]          perf_read_stall_r;

  logic [31:0]          rem_s;
  logic [31:0]          n_s;
  logic [SIZE_W-1:0]    size_s;
  logic                 line_end_s;
  logic                 surf_end_s;
  logic                 layer_end_s;
  logic                 reserve_s;
  logic [CR_W-1:0]      rsv_amt_s;
  logic                 pop_ok_s;
  logic [AW-1:0]        atom_off_s;
  logic [AW-1:0]        req_addr_s;
  logic [AW-1:0]        line_stride_ext_s;
  logic [AW-1:0]        surf_stride_ext_s;
  logic [AW-1:0]        next_surf_addr_s;
  logic [CNT_W-1:0]     step_s;
  logic                 rd_done_s;
  logic                 cq_done_s;
  logic                 stall_s;

  // Burst sizing, boundary flags, credit decision and address arithmetic.
  always_comb begin
    rem_s = 32'(cfg_width_r) + 32'd1 - 32'(atom_cnt_r);
    if (rem_s > 32'(MAX_BURST)) begin
      n_s = 32'(MAX_BURST);
    end else begin
      n_s = rem_s;
    end
    size_s      = SIZE_W'(n_s - 32'd1);
    // The burst closes the line exactly when it takes all remaining atoms.
    line_end_s  = (rem_s <= 32'(MAX_BURST));
    surf_end_s  = line_end_s && (line_cnt_r == cfg_height_r);
    layer_end_s = surf_end_s && (surf_cnt_r == cfg_surfaces_r);
    reserve_s   = (state_r == GEN) && (32'(credit_r) >= n_s);
    if (reserve_s) begin
      rsv_amt_s = CR_W'(n_s);
    end else begin
      rsv_amt_s = {CR_W{1'b0}};
    end
    // A pop on a full pool is dropped so the counter saturates.
    pop_ok_s          = cdt_lat_fifo_pop && (credit_r != CR_W'(LAT_DEPTH));
    atom_off_s        = {{(AW-CNT_W){1'b0}}, atom_cnt_r} << SHIFT;
    req_addr_s        = line_addr_r + atom_off_s;
    line_stride_ext_s = {{(AW-32){1'b0}}, line_stride_r};
    surf_stride_ext_s = {{(AW-32){1'b0}}, surf_stride_r};
    next_surf_addr_s  = surf_addr_r + surf_stride_ext_s;
    // Atoms in the in-flight request, recovered from its size field.
    step_s            = {{(CNT_W-SIZE_W){1'b0}}, ig2cq_pd_r[SIZE_W-1:0]} + CNT_ONE;
    rd_done_s         = !rd_req_valid_r || rd_req_ready;
    cq_done_s         = !ig2cq_pvld_r || ig2cq_prdy;
    stall_s           = rd_req_valid_r && !rd_req_ready;
  end

  // Credit pool: returns and reservations in the same cycle both apply.
  always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
    if (nvdla_core_rst) begin
      credit_r <= CR_W'(LAT_DEPTH);
    end else begin
      credit_r <= credit_r + {{(CR_W-1){1'b0}}, pop_ok_s} - rsv_amt_s;
    end
  end

  // Layer FSM with cube walk counters, output registers and stall counter.
  always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
    if (nvdla_core_rst) begin
      state_r           <= IDLE;
      line_stride_r     <= 32'd0;
      surf_stride_r     <= 32'd0;
      cfg_width_r       <= {CNT_W{1'b0}};
      cfg_height_r      <= {CNT_W{1'b0}};
      cfg_surfaces_r    <= {CNT_W{1'b0}};
      surf_addr_r       <= {AW{1'b0}};
      line_addr_r       <= {AW{1'b0}};
      atom_cnt_r        <= {CNT_W{1'b0}};
      line_cnt_r        <= {CNT_W{1'b0}};
      surf_cnt_r        <= {CNT_W{1'b0}};
      rd_req_valid_r    <= 1'b0;
      rd_req_pd_r       <= {(AW+SIZE_W){1'b0}};
      ig2cq_pvld_r      <= 1'b0;
      ig2cq_pd_r        <= {(SIZE_W+3){1'b0}};
      layer_done_r      <= 1'b0;
      busy_r            <= 1'b0;
      perf_read_stall_r <= 32'd0;
    end else begin
      layer_done_r <= 1'b0;
      if (stall_s && (perf_read_stall_r != 32'hFFFF_FFFF)) begin
        perf_read_stall_r <= perf_read_stall_r + 32'd1;
      end
      case (state_r)
        IDLE: begin
          if (op_en) begin
            line_stride_r     <= cfg_line_stride;
            surf_stride_r     <= cfg_surf_stride;
            cfg_width_r       <= cfg_width;
            cfg_height_r      <= cfg_height;
            cfg_surfaces_r    <= cfg_surfaces;
            surf_addr_r       <= cfg_base_addr;
            line_addr_r       <= cfg_base_addr;
            atom_cnt_r        <= {CNT_W{1'b0}};
            line_cnt_r        <= {CNT_W{1'b0}};
            surf_cnt_r        <= {CNT_W{1'b0}};
            perf_read_stall_r <= 32'd0;
            busy_r            <= 1'b1;
            state_r           <= GEN;
          end
        end
        GEN: begin
          if (reserve_s) begin
            rd_req_pd_r    <= {size_s, req_addr_s};
            ig2cq_pd_r     <= {layer_end_s, surf_end_s, line_end_s, size_s};
            rd_req_valid_r <= 1'b1;
            ig2cq_pvld_r   <= 1'b1;
            state_r        <= SEND;
          end
        end
        SEND: begin
          if (rd_req_valid_r && rd_req_ready) begin
            rd_req_valid_r <= 1'b0;
          end
          if (ig2cq_pvld_r && ig2cq_prdy) begin
            ig2cq_pvld_r <= 1'b0;
          end
          // Advance only once both sides have taken this request.
          if (rd_done_s && cq_done_s) begin
            state_r <= GEN;
            if (!ig2cq_pd_r[SIZE_W]) begin
              atom_cnt_r <= atom_cnt_r + step_s;
            end else begin
              atom_cnt_r <= {CNT_W{1'b0}};
              if (!ig2cq_pd_r[SIZE_W+1]) begin
                line_cnt_r  <= line_cnt_r + CNT_ONE;
                line_addr_r <= line_addr_r + line_stride_ext_s;
              end else begin
                line_cnt_r  <= {CNT_W{1'b0}};
                surf_addr_r <= next_surf_addr_s;
                line_addr_r <= next_surf_addr_s;
                if (ig2cq_pd_r[SIZE_W+2]) begin
                  surf_cnt_r <= {CNT_W{1'b0}};
                  state_r    <= WAIT;
                end else begin
                  surf_cnt_r <= surf_cnt_r + CNT_ONE;
                end
              end
            end
          end
        end
        WAIT: begin
          if (eg2ig_done) begin
            layer_done_r <= 1'b1;
            busy_r       <= 1'b0;
            state_r      <= IDLE;
          end
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign rd_req_valid    = rd_req_valid_r;
  assign rd_req_pd       = rd_req_pd_r;
  assign ig2cq_pvld      = ig2cq_pvld_r;
  assign ig2cq_pd        = ig2cq_pd_r;
  assign layer_done      = layer_done_r;
  assign busy            = busy_r;
  assign perf_read_stall = perf_read_stall_r;

  pdp_rdma_ig_cdt_chk #(
    .LAT_DEPTH (LAT_DEPTH),
    .CR_W      (CR_W)
  ) u_chk (
    .clk    (nvdla_core_clk),
    .rst    (nvdla_core_rst),
    .pop    (cdt_lat_fifo_pop),
    .credit (credit_r)
  );

endmodule

// File: tb/tb_pdp_rdma_ig_cdt.sv
`timescale 1ns/1ps
module tb_pdp_rdma_ig_cdt;

  localparam int AW     = 64;
  localparam int SIZE_W = 4;
  localparam int CNT_W  = 13;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 op_en = 1'b0;
  logic [AW-1:0]        cfg_base_addr = '0;
  logic [31:0]          cfg_line_stride = '0;
  logic [31:0]          cfg_surf_stride = '0;
  logic [CNT_W-1:0]     cfg_width = '0;
  logic [CNT_W-1:0]     cfg_height = '0;
  logic [CNT_W-1:0]     cfg_surfaces = '0;
  logic                 rd_req_valid;
  logic                 rd_req_ready = 1'b1;
  logic [AW+SIZE_W-1:0] rd_req_pd;
  logic                 ig2cq_pvld;
  logic                 ig2cq_prdy = 1'b1;
  logic [SIZE_W+2:0]    ig2cq_pd;
  logic                 cdt_lat_fifo_pop = 1'b0;
  logic                 eg2ig_done = 1'b0;
  logic                 layer_done;
  logic                 busy;
  logic [31:0]          perf_read_stall;

  logic [AW+SIZE_W-1:0] rd_q[$];
  logic [SIZE_W+2:0]    cq_q[$];
  logic [AW+SIZE_W-1:0] mon_rd_exp;
  logic [SIZE_W+2:0]    mon_cq_exp;
  int pass_cnt = 0;
  int total_cnt = 0;
  int outstanding = 0;

  always #5 clk = ~clk;

  pdp_rdma_ig_cdt dut (
    .nvdla_core_clk   (clk),
    .nvdla_core_rst   (rst),
    .op_en            (op_en),
    .cfg_base_addr    (cfg_base_addr),
    .cfg_line_stride  (cfg_line_stride),
    .cfg_surf_stride  (cfg_surf_stride),
    .cfg_width        (cfg_width),
    .cfg_height       (cfg_height),
    .cfg_surfaces     (cfg_surfaces),
    .rd_req_valid     (rd_req_valid),
    .rd_req_ready     (rd_req_ready),
    .rd_req_pd        (rd_req_pd),
    .ig2cq_pvld       (ig2cq_pvld),
    .ig2cq_prdy       (ig2cq_prdy),
    .ig2cq_pd         (ig2cq_pd),
    .cdt_lat_fifo_pop (cdt_lat_fifo_pop),
    .eg2ig_done       (eg2ig_done),
    .layer_done       (layer_done),
    .busy             (busy),
    .perf_read_stall  (perf_read_stall)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_req(input logic [AW-1:0] addr, input int n, input logic [2:0] flags);
    rd_q.push_back({SIZE_W'(n - 1), addr});
    cq_q.push_back({flags, SIZE_W'(n - 1)});
    outstanding += n;
  endtask

  task automatic start_layer(input logic [AW-1:0] base, input logic [31:0] ls, input logic [31:0] ss,
                             input logic [CNT_W-1:0] w, input logic [CNT_W-1:0] h,
                             input logic [CNT_W-1:0] s);
    cfg_base_addr   = base;
    cfg_line_stride = ls;
    cfg_surf_stride = ss;
    cfg_width       = w;
    cfg_height      = h;
    cfg_surfaces    = s;
    op_en           = 1'b1;
    tick();
    op_en           = 1'b0;
  endtask

  task automatic wait_drain(input int max_cyc, input string name);
    int c = 0;
    while ((rd_q.size() != 0 || cq_q.size() != 0) && c < max_cyc) begin
      tick();
      c++;
    end
    chk({name, "_drained"}, c < max_cyc, 1'b1);
  endtask

  task automatic wait_valid(input int max_cyc, input string name);
    int c = 0;
    while (!rd_req_valid && c < max_cyc) begin
      tick();
      c++;
    end
    chk({name, "_valid_seen"}, rd_req_valid, 1'b1);
  endtask

  task automatic finish_layer(input string name);
    tick();
    tick();
    chk({name, "_busy_in_wait"}, busy, 1'b1);
    chk({name, "_no_early_done"}, layer_done, 1'b0);
    eg2ig_done = 1'b1;
    tick();
    eg2ig_done = 1'b0;
    chk({name, "_layer_done"}, layer_done, 1'b1);
    chk({name, "_busy_fall"}, busy, 1'b0);
    tick();
    chk({name, "_done_one_cycle"}, layer_done, 1'b0);
  endtask

  task automatic return_credits();
    while (outstanding > 0) begin
      cdt_lat_fifo_pop = 1'b1;
      tick();
      outstanding--;
    end
    cdt_lat_fifo_pop = 1'b0;
  endtask

  // Scoreboard monitor: compare each handshake against the queued expectation.
  always @(negedge clk) begin
    if (!rst) begin
      if (rd_req_valid && rd_req_ready) begin
        chk("rd_req_expected", rd_q.size() != 0, 1'b1);
        if (rd_q.size() != 0) begin
          mon_rd_exp = rd_q.pop_front();
          chk("rd_req_pd", rd_req_pd, mon_rd_exp);
        end
      end
      if (ig2cq_pvld && ig2cq_prdy) begin
        chk("ig2cq_expected", cq_q.size() != 0, 1'b1);
        if (cq_q.size() != 0) begin
          mon_cq_exp = cq_q.pop_front();
          chk("ig2cq_pd", ig2cq_pd, mon_cq_exp);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rd_valid", rd_req_valid, 1'b0);
    chk("rst_cq_valid", ig2cq_pvld, 1'b0);
    chk("rst_layer_done", layer_done, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_perf", perf_read_stall, 32'd0);
    chk("rst_rd_pd", rd_req_pd, 68'd0);
    chk("rst_cq_pd", ig2cq_pd, 7'd0);
    chk("rst_credit", dut.credit_r, 7'd64);
    rst = 1'b0;
    tick();

    // Single request
    push_req(64'h1000, 4, 3'b111);
    start_layer(64'h1000, 32'h100, 32'h1000, 13'd3, 13'd0, 13'd0);
    wait_drain(50, "t1");
    finish_layer("t1");
    return_credits();

    // Burst split over two lines
    push_req(64'h000, 8, 3'b000);
    push_req(64'h100, 8, 3'b000);
    push_req(64'h200, 3, 3'b001);
    push_req(64'h400, 8, 3'b000);
    push_req(64'h500, 8, 3'b000);
    push_req(64'h600, 3, 3'b111);
    start_layer(64'h0, 32'h400, 32'h10000, 13'd18, 13'd1, 13'd0);
    wait_drain(100, "t2");
    finish_layer("t2");
    return_credits();

    // Credit stall: 80 atoms against a 64-atom pool
    for (int i = 0; i < 10; i++)
      push_req(64'h2000 + 64'(i) * 64'h100, 8, (i == 9) ? 3'b111 : 3'b000);
    start_layer(64'h2000, 32'h1000, 32'h10000, 13'd79, 13'd0, 13'd0);
    repeat (30) tick();
    chk("t3_pending", rd_q.size(), 2);
    chk("t3_no_valid", rd_req_valid, 1'b0);
    chk("t3_credit_empty", dut.credit_r, 7'd0);
    repeat (5) tick();
    chk("t3_still_held", rd_req_valid, 1'b0);
    for (int i = 0; i < 8; i++) begin
      cdt_lat_fifo_pop = 1'b1;
      tick();
    end
    cdt_lat_fifo_pop = 1'b0;
    outstanding -= 8;
    chk("t3_credit_back", dut.credit_r, 7'd8);
    chk("t3_not_yet", rd_req_valid, 1'b0);
    tick();
    chk("t3_issue", rd_req_valid, 1'b1);
    chk("t3_credit_resv", dut.credit_r, 7'd0);
    chk("t3_issue_pd", rd_req_pd, {4'd7, 64'h2800});
    for (int i = 0; i < 8; i++) begin
      cdt_lat_fifo_pop = 1'b1;
      tick();
    end
    cdt_lat_fifo_pop = 1'b0;
    outstanding -= 8;
    wait_drain(50, "t3");
    finish_layer("t3");
    return_credits();

    // Independent backpressure
    rd_req_ready = 1'b0;
    ig2cq_prdy   = 1'b0;
    push_req(64'h3000, 8, 3'b111);
    start_layer(64'h3000, 32'h100, 32'h1000, 13'd7, 13'd0, 13'd0);
    wait_valid(20, "t4");
    eg2ig_done = 1'b1;
    tick();
    eg2ig_done = 1'b0;
    chk("t4_done_ignored", layer_done, 1'b0);
    tick();
    tick();
    rd_req_ready = 1'b1;
    tick();
    chk("t4_rd_taken", rd_req_valid, 1'b0);
    chk("t4_cq_held", ig2cq_pvld, 1'b1);
    chk("t4_cq_stable", ig2cq_pd, {3'b111, 4'd7});
    tick();
    tick();
    chk("t4_cq_still", ig2cq_pvld, 1'b1);
    chk("t4_no_new_req", rd_req_valid, 1'b0);
    chk("t4_perf", perf_read_stall, 32'd3);
    ig2cq_prdy = 1'b1;
    wait_drain(20, "t4");
    finish_layer("t4");
    chk("t4_perf_hold", perf_read_stall, 32'd3);
    return_credits();

    // Reset mid-layer with 40 credits left
    rd_req_ready = 1'b0;
    ig2cq_prdy   = 1'b0;
    start_layer(64'h5000, 32'h1000, 32'h10000, 13'd63, 13'd0, 13'd0);
    for (int i = 0; i < 2; i++) begin
      push_req(64'h5000 + 64'(i) * 64'h100, 8, 3'b000);
      wait_valid(20, "t5_req");
      rd_req_ready = 1'b1;
      ig2cq_prdy   = 1'b1;
      tick();
      rd_req_ready = 1'b0;
      ig2cq_prdy   = 1'b0;
    end
    wait_valid(20, "t5_third");
    chk("t5_credit40", dut.credit_r, 7'd40);
    tick();
    #3;
    rst = 1'b1;
    #1;
    chk("t5_rst_rd_valid", rd_req_valid, 1'b0);
    chk("t5_rst_cq_valid", ig2cq_pvld, 1'b0);
    chk("t5_rst_busy", busy, 1'b0);
    chk("t5_rst_rd_pd", rd_req_pd, 68'd0);
    chk("t5_rst_perf", perf_read_stall, 32'd0);
    outstanding = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick();
    chk("t5_credit_full", dut.credit_r, 7'd64);
    rd_req_ready = 1'b1;
    ig2cq_prdy   = 1'b1;
    push_req(64'h8000, 1, 3'b111);
    start_layer(64'h8000, 32'h100, 32'h1000, 13'd0, 13'd0, 13'd0);
    wait_drain(20, "t5");
    finish_layer("t5");
    return_credits();

    // Surface wrap modulo 2^64, op_en mid-layer ignored
    push_req(64'hFFFF_FFFF_FFFF_FF00, 1, 3'b011);
    push_req(64'h0000_0000_0000_0100, 1, 3'b111);
    start_layer(64'hFFFF_FFFF_FFFF_FF00, 32'h40, 32'h200, 13'd0, 13'd0, 13'd1);
    cfg_base_addr = 64'h0;
    cfg_width     = 13'd5;
    op_en = 1'b1;
    tick();
    op_en = 1'b0;
    wait_drain(30, "t6");
    finish_layer("t6");
    tick();
    tick();
    chk("t6_stays_idle", busy, 1'b0);
    chk("t6_no_stray_req", rd_req_valid, 1'b0);
    return_credits();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
